// File: rtl/tdc_meas_ctrl.sv
// tdc_meas_ctrl: burst TDC sequencer (clear, launch, wait, settle, capture) with tap-count averaging.
// Define TDC_BUBBLE_FIX_EN to count leading ones instead of the population count.
module tdc_meas_ctrl #(
    parameter int N_DELAY     = 32,
    parameter int AVG_LOG2    = 3,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 255,
    localparam int CW         = $clog2(N_DELAY + 1),
    localparam int AW         = CW + AVG_LOG2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_req,
    input  logic               tdc_hit,
    input  logic [N_DELAY-1:0] tdc_code,
    input  logic [1:0]         byte_sel,
    output logic               tdc_clr,
    output logic               tdc_arm,
    output logic               busy,
    output logic               result_valid,
    output logic [AW-1:0]      result_sum,
    output logic [CW-1:0]      result_avg,
    output logic               timeout,
    output logic [7:0]         code_byte
);
    localparam int TMAX = TIMEOUT_CYC > SETTLE_CYC ? TIMEOUT_CYC : SETTLE_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int SW   = AVG_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, SETTLE, CAPTURE, DONE} state_e;

    state_e             state_q;
    logic [TW-1:0]      cnt_q;
    logic [SW-1:0]      smp_q;
    logic [AW-1:0]      acc_q;
    logic [AW-1:0]      acc_d;
    logic [AW-1:0]      sum_q;
    logic [N_DELAY-1:0] last_q;
    logic [CW-1:0]      count_d;
    logic               clr_q;
    logic               arm_q;
    logic               busy_q;
    logic               valid_q;
    logic               timeout_q;

    function automatic logic [CW-1:0] tap_count(input logic [N_DELAY-1:0] c);
        logic [CW-1:0] n;
`ifdef TDC_BUBBLE_FIX_EN
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < N_DELAY; i++) begin
            run = run & c[i];
            n   = n + CW'(run);
        end
`else
        n = '0;
        for (int i = 0; i < N_DELAY; i++) n = n + CW'(c[i]);
`endif
        return n;
    endfunction

    assign count_d = tap_count(tdc_code);
    assign acc_d   = acc_q + AW'(count_d);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            smp_q     <= '0;
            acc_q     <= '0;
            sum_q     <= '0;
            last_q    <= '0;
            clr_q     <= 1'b0;
            arm_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clr_q   <= 1'b0;
            arm_q   <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start_req) begin
                    state_q   <= CLEAR;
                    clr_q     <= 1'b1;
                    busy_q    <= 1'b1;
                    acc_q     <= '0;
                    smp_q     <= '0;
                    timeout_q <= 1'b0;
                end
                CLEAR: begin
                    state_q <= LAUNCH;
                    arm_q   <= 1'b1;
                end
                LAUNCH: begin
                    state_q <= WAIT;
                    cnt_q   <= '0;
                end
                // a hit wins over the timeout on the final wait cycle
                WAIT: if (tdc_hit) begin
                    state_q <= SETTLE;
                    cnt_q   <= '0;
                end else if (cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_q   <= DONE;
                    valid_q   <= 1'b1;
                    sum_q     <= '0;
                    timeout_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                SETTLE: if (cnt_q == TW'(SETTLE_CYC - 1)) state_q <= CAPTURE;
                        else cnt_q <= cnt_q + 1'b1;
                CAPTURE: begin
                    last_q <= tdc_code;
                    acc_q  <= acc_d;
                    smp_q  <= smp_q + 1'b1;
                    if (smp_q == SW'((1 << AVG_LOG2) - 1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        sum_q   <= acc_d;
                    end else begin
                        state_q <= CLEAR;
                        clr_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tdc_clr      = clr_q;
    assign tdc_arm      = arm_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign timeout      = timeout_q;
    assign result_sum   = sum_q;
    assign result_avg   = sum_q[AW-1:AVG_LOG2];
    assign code_byte    = 8'({32'b0, last_q} >> {byte_sel, 3'b000});
endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb_tdc_meas_ctrl: directed bench for tdc_meas_ctrl at default parameters.
module tb_tdc_meas_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_req = 1'b0;
    logic        tdc_hit = 1'b0;
    logic [31:0] tdc_code = '0;
    logic [1:0]  byte_sel = '0;
    logic        tdc_clr, tdc_arm, busy, result_valid, timeout;
    logic [8:0]  result_sum;
    logic [5:0]  result_avg;
    logic [7:0]  code_byte;

    int checks = 0;
    int errors = 0;
    int arms = 0, cyc = 0, since_arm = 0, hd = 0;
    bit hit_on = 1'b0;

`ifdef TDC_BUBBLE_FIX_EN
    localparam int BUB_SUM = 24, BUB_AVG = 3, RD_SUM = 96, RD_AVG = 12;
`else
    localparam int BUB_SUM = 56, BUB_AVG = 7, RD_SUM = 160, RD_AVG = 20;
`endif

    tdc_meas_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_req(start_req), .tdc_hit(tdc_hit),
        .tdc_code(tdc_code), .byte_sel(byte_sel), .tdc_clr(tdc_clr), .tdc_arm(tdc_arm),
        .busy(busy), .result_valid(result_valid), .result_sum(result_sum),
        .result_avg(result_avg), .timeout(timeout), .code_byte(code_byte)
    );

    always #5 clk = ~clk;

    // delay-line stand-in: raise tdc_hit two cycles after each tdc_arm
    task automatic step();
        @(negedge clk);
        cyc++;
        since_arm++;
        if (tdc_arm) begin
            arms++;
            since_arm = 0;
            hd = 2;
            tdc_hit = 1'b0;
        end else if (hd > 0) begin
            hd--;
            tdc_hit = hit_on && hd == 0;
        end else begin
            tdc_hit = 1'b0;
        end
    endtask

    task automatic run_burst(input logic [31:0] code, input bit hit, input bit hold, input bit pulse_mid,
                             output bit clr1, output bit busy1, output bit to1, output bit arm2);
        bit got = 1'b0;
        tdc_code = code;
        hit_on = hit;
        arms = 0;
        cyc = 0;
        since_arm = 0;
        hd = 0;
        start_req = 1'b1;
        while (!got && cyc < 2000) begin
            step();
            if (cyc == 1) begin
                clr1 = tdc_clr;
                busy1 = busy;
                to1 = timeout;
                if (!hold) start_req = 1'b0;
            end
            if (cyc == 2) arm2 = tdc_arm;
            if (pulse_mid && cyc == 10) start_req = 1'b1;
            if (pulse_mid && cyc == 11) start_req = 1'b0;
            if (result_valid) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL burst_done: no result_valid within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tdc_clr, tdc_arm, busy, result_valid, timeout} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000", {tdc_clr, tdc_arm, busy, result_valid, timeout});
        end
        checks++;
        if (result_sum !== 9'd0 || result_avg !== 6'd0) begin
            errors++;
            $display("FAIL reset_result: got sum %0d avg %0d want 0 0", result_sum, result_avg);
        end
        for (int i = 0; i < 4; i++) begin
            byte_sel = 2'(i);
            #1;
            checks++;
            if (code_byte !== 8'h00) begin
                errors++;
                $display("FAIL reset_byte%0d: got %h want 00", i, code_byte);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        bit clr1, busy1, to1, arm2;
        run_burst(32'h0000_FFFF, 1'b1, 1'b0, 1'b0, clr1, busy1, to1, arm2);
        checks++;
        if (clr1 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL start_clr_busy: got clr %b busy %b want 1 1", clr1, busy1);
        end
        checks++;
        if (arm2 !== 1'b1) begin
            errors++;
            $display("FAIL start_arm: got %b want 1", arm2);
        end
        checks++;
        if (arms != 8) begin
            errors++;
            $display("FAIL burst_arms: got %0d want 8", arms);
        end
        checks++;
        if (cyc != 57) begin
            errors++;
            $display("FAIL burst_latency: got %0d want 57", cyc);
        end
        checks++;
        if (result_sum !== 9'd128 || result_avg !== 6'd16 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL burst_result: got sum %0d avg %0d to %b want 128 16 0", result_sum, result_avg, timeout);
        end
        step();
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_sum !== 9'd128) begin
            errors++;
            $display("FAIL burst_after: got busy %b valid %b sum %0d want 0 0 128", busy, result_valid, result_sum);
        end
    endtask

    task automatic test_timeout();
        bit clr1, busy1, to1, arm2;
        run_burst(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, clr1, busy1, to1, arm2);
        checks++;
        if (arms != 1 || since_arm != 256) begin
            errors++;
            $display("FAIL timeout_wait: got arms %0d cycles %0d want 1 256", arms, since_arm);
        end
        checks++;
        if (timeout !== 1'b1 || result_sum !== 9'd0 || result_avg !== 6'd0) begin
            errors++;
            $display("FAIL timeout_result: got to %b sum %0d avg %0d want 1 0 0", timeout, result_sum, result_avg);
        end
        repeat (3) step();
        checks++;
        if (timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got %b want 1", timeout);
        end
    endtask

    task automatic test_bubble();
        bit clr1, busy1, to1, arm2;
        run_burst(32'h0000_00F7, 1'b1, 1'b0, 1'b0, clr1, busy1, to1, arm2);
        checks++;
        if (to1 !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b want 0", to1);
        end
        checks++;
        if (result_sum !== 9'(BUB_SUM) || result_avg !== 6'(BUB_AVG) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL bubble_result: got sum %0d avg %0d to %b want %0d %0d 0",
                     result_sum, result_avg, timeout, BUB_SUM, BUB_AVG);
        end
        step();
    endtask

    task automatic test_readout();
        bit clr1, busy1, to1, arm2;
        logic [7:0] exp_b [4] = '{8'hFF, 8'h0F, 8'hC3, 8'hA5};
        run_burst(32'hA5C3_0FFF, 1'b1, 1'b0, 1'b0, clr1, busy1, to1, arm2);
        checks++;
        if (result_sum !== 9'(RD_SUM) || result_avg !== 6'(RD_AVG)) begin
            errors++;
            $display("FAIL readout_result: got sum %0d avg %0d want %0d %0d", result_sum, result_avg, RD_SUM, RD_AVG);
        end
        for (int i = 0; i < 4; i++) begin
            byte_sel = 2'(i);
            #1;
            checks++;
            if (code_byte !== exp_b[i]) begin
                errors++;
                $display("FAIL readout_byte%0d: got %h want %h", i, code_byte, exp_b[i]);
            end
        end
        step();
    endtask

    task automatic test_busy_start();
        bit clr1, busy1, to1, arm2;
        bit extra = 1'b0;
        run_burst(32'h0000_FFFF, 1'b1, 1'b0, 1'b1, clr1, busy1, to1, arm2);
        checks++;
        if (arms != 8 || result_sum !== 9'd128) begin
            errors++;
            $display("FAIL busy_start_burst: got arms %0d sum %0d want 8 128", arms, result_sum);
        end
        repeat (4) begin
            step();
            if (busy || result_valid) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL busy_start_extra: got extra burst 1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        bit clr1, busy1, to1, arm2;
        bit got = 1'b0;
        int n = 0;
        run_burst(32'h0000_FFFF, 1'b1, 1'b1, 1'b0, clr1, busy1, to1, arm2);
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got busy %b want 0", busy);
        end
        step();
        checks++;
        if (busy !== 1'b1 || tdc_clr !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got busy %b clr %b want 1 1", busy, tdc_clr);
        end
        start_req = 1'b0;
        while (!got && n < 200) begin
            step();
            n++;
            if (result_valid) got = 1'b1;
        end
        checks++;
        if (!got || result_sum !== 9'd128) begin
            errors++;
            $display("FAIL b2b_second: got valid %b sum %0d want 1 128", got, result_sum);
        end
        step();
    endtask

    task automatic test_mid_reset();
        bit seen = 1'b0;
        tdc_code = 32'h0000_FFFF;
        hit_on = 1'b1;
        arms = 0;
        cyc = 0;
        since_arm = 0;
        hd = 0;
        start_req = 1'b1;
        step();
        start_req = 1'b0;
        while (!(arms >= 1 && since_arm == 3) && cyc < 100) step();
        checks++;
        if (cyc >= 100) begin
            errors++;
            $display("FAIL mid_reset_reach: got no settle phase in %0d cycles want <100", cyc);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || tdc_arm !== 1'b0 || result_valid !== 1'b0 || result_sum !== 9'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got busy %b arm %b valid %b sum %0d want 0 0 0 0",
                     busy, tdc_arm, result_valid, result_sum);
        end
        rst_n = 1'b1;
        repeat (20) begin
            step();
            if (result_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_quiet: got activity 1 want 0");
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_timeout();
        test_bubble();
        test_readout();
        test_busy_start();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
